intrusion_sequencer: RTL and testbench

Top-level sequencer for the security alarm. When armed, it brings up the audio codec, schedules periodic HC-SR04 measurements through the sensor controller, and debounces the returned distance against a threshold. It then drives the sound generator enable for a fixed alarm window, followed by a cooldown. It runs on the divided trigger clock (T_CLK) alongside the sensor controller, codec configurator and sound generator.

---
 rtl/intrusion_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_intrusion_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intrusion_sequencer.sv
// Alarm sequencer: arms the codec, paces HC-SR04 pings, debounces hits against a
// distance threshold, then runs a fixed alarm window followed by a cooldown.
module intrusion_sequencer #(
  parameter int unsigned THRESH       = 100,
  parameter int unsigned HITS         = 3,
  parameter int unsigned PING_PERIOD  = 60000,
  parameter int unsigned ECHO_TIMEOUT = 40000,
  parameter int unsigned ALARM_HOLD   = 500000,
  parameter int unsigned COOLDOWN     = 250000,
  parameter int unsigned FAULT_LIMIT  = 4,
  parameter int unsigned CNT_W        = 24
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Arm,
  input  logic       Codec_Ready,
  input  logic       Meas_Done,
  input  logic [7:0] Distance,
  output logic       Meas_Start,
  output logic       Codec_Start,
  output logic       Sound_En,
  output logic       Alarm_Active,
  output logic       Sensor_Fault,
  output logic [2:0] State
);

  localparam int unsigned FLAG_W = 4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CONFIG   = 3'd1,
    S_WAIT     = 3'd2,
    S_PING     = 3'd3,
    S_ALARM    = 3'd4,
    S_COOLDOWN = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0]  PING_LAST  = CNT_W'(PING_PERIOD - 1);
  localparam logic [CNT_W-1:0]  ECHO_LAST  = CNT_W'(ECHO_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  ALARM_LAST = CNT_W'(ALARM_HOLD - 1);
  localparam logic [CNT_W-1:0]  COOL_LAST  = CNT_W'(COOLDOWN - 1);
  localparam logic [7:0]        THRESH_V   = 8'(THRESH);
  localparam logic [FLAG_W-1:0] HITS_V     = FLAG_W'(HITS);
  localparam logic [FLAG_W-1:0] FAULT_V    = FLAG_W'(FAULT_LIMIT);
  localparam logic [FLAG_W-1:0] TMO_MAX    = '1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FLAG_W-1:0]  hits_q, hits_d;
  logic [FLAG_W-1:0]  tmo_q, tmo_d;
  logic               fault_q, fault_d;
  logic               meas_start_q, meas_start_d;
  logic               codec_start_q, codec_start_d;
  logic               sound_en_q, sound_en_d;
  logic               alarm_active_q, alarm_active_d;
  logic [FLAG_W-1:0]  hits_inc, tmo_inc;
  logic [CNT_W-1:0]   cnt_inc;

  assign hits_inc = hits_q + FLAG_W'(1);
  assign tmo_inc  = (tmo_q == TMO_MAX) ? TMO_MAX : tmo_q + FLAG_W'(1);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Next-state logic; disarm overrides every transition and clears all bookkeeping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hits_d  = hits_q;
    tmo_d   = tmo_q;
    fault_d = fault_q;
    if (!Arm) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      hits_d  = '0;
      tmo_d   = '0;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_CONFIG;
          cnt_d   = '0;
        end
        S_CONFIG: begin
          if (Codec_Ready) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
        S_WAIT: begin
          if (cnt_q == PING_LAST) begin
            state_d = S_PING;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_PING: begin
          // A measurement landing on the timeout cycle wins over the timeout
          if (Meas_Done) begin
            cnt_d = '0;
            tmo_d = '0;
            if (Distance < THRESH_V) begin
              hits_d  = hits_inc;
              state_d = (hits_inc == HITS_V) ? S_ALARM : S_WAIT;
            end else begin
              hits_d  = '0;
              state_d = S_WAIT;
            end
          end else if (cnt_q == ECHO_LAST) begin
            cnt_d   = '0;
            hits_d  = '0;
            tmo_d   = tmo_inc;
            state_d = S_WAIT;
            if (tmo_inc == FAULT_V) fault_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_ALARM: begin
          if (cnt_q == ALARM_LAST) begin
            state_d = S_COOLDOWN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_COOLDOWN: begin
          if (cnt_q == COOL_LAST) begin
            state_d = S_WAIT;
            cnt_d   = '0;
            hits_d  = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          hits_d  = '0;
          tmo_d   = '0;
          fault_d = 1'b0;
        end
      endcase
    end
  end

  // Outputs decoded from the next state so they register together with it
  always_comb begin
    meas_start_d   = 1'b0;
    codec_start_d  = 1'b0;
    sound_en_d     = 1'b0;
    alarm_active_d = 1'b0;
    meas_start_d   = (state_d == S_PING) && (state_q != S_PING);
    codec_start_d  = (state_d != S_IDLE);
    sound_en_d     = (state_d == S_ALARM);
    alarm_active_d = (state_d == S_ALARM) || (state_d == S_COOLDOWN);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      hits_q         <= '0;
      tmo_q          <= '0;
      fault_q        <= 1'b0;
      meas_start_q   <= 1'b0;
      codec_start_q  <= 1'b0;
      sound_en_q     <= 1'b0;
      alarm_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      hits_q         <= hits_d;
      tmo_q          <= tmo_d;
      fault_q        <= fault_d;
      meas_start_q   <= meas_start_d;
      codec_start_q  <= codec_start_d;
      sound_en_q     <= sound_en_d;
      alarm_active_q <= alarm_active_d;
    end
  end

  assign Meas_Start   = meas_start_q;
  assign Codec_Start  = codec_start_q;
  assign Sound_En     = sound_en_q;
  assign Alarm_Active = alarm_active_q;
  assign Sensor_Fault = fault_q;
  assign State        = state_q;

endmodule

// File: tb/tb_intrusion_sequencer.sv
// Directed scenario bench for intrusion_sequencer with small cycle parameters.
module tb_intrusion_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       arm = 1'b0;
  logic       codec_ready = 1'b0;
  logic       meas_done = 1'b0;
  logic [7:0] distance = 8'd0;
  logic       meas_start, codec_start, sound_en, alarm_active, sensor_fault;
  logic [2:0] state;

  int passed = 0;
  int total  = 0;

  intrusion_sequencer #(
    .THRESH(100), .HITS(3), .PING_PERIOD(10), .ECHO_TIMEOUT(20),
    .ALARM_HOLD(50), .COOLDOWN(30), .FAULT_LIMIT(4), .CNT_W(24)
  ) dut (
    .CLK(clk), .RST(rst), .Arm(arm), .Codec_Ready(codec_ready),
    .Meas_Done(meas_done), .Distance(distance),
    .Meas_Start(meas_start), .Codec_Start(codec_start), .Sound_En(sound_en),
    .Alarm_Active(alarm_active), .Sensor_Fault(sensor_fault), .State(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles until the next Meas_Start pulse, or -1 if the budget runs out
  task automatic wait_ms(input int budget, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (meas_start !== 1'b1 && cycles < budget);
    if (meas_start !== 1'b1) cycles = -1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (state !== s && cycles < budget);
    if (state !== s) cycles = -1;
  endtask

  task automatic respond(input logic [7:0] d);
    meas_done = 1'b1;
    distance  = d;
    tick();
    meas_done = 1'b0;
  endtask

  task automatic test_reset();
    int c;
    rst = 1'b0; arm = 1'b1;
    repeat (5) tick();
    total++;
    if ({meas_start, codec_start, sound_en, alarm_active, sensor_fault, state} !== 8'h00)
      $display("FAIL reset_outputs got %h expected 00",
               {meas_start, codec_start, sound_en, alarm_active, sensor_fault, state});
    else passed++;
    rst = 1'b1;
    tick();
    total++;
    if ({state, codec_start} !== 4'b0011)
      $display("FAIL bringup_config got state=%0d codec_start=%b expected state=1 codec_start=1", state, codec_start);
    else passed++;
    codec_ready = 1'b1;
    tick();
    codec_ready = 1'b0;
    total++;
    if (state !== 3'd2) $display("FAIL bringup_wait got state=%0d expected 2", state);
    else passed++;
    wait_ms(40, c);
    total++;
    if (c != 10) $display("FAIL first_ping_latency got %0d expected 10", c);
    else passed++;
  endtask

  task automatic test_debounce();
    int c;
    logic [7:0] tab [6];
    tab[0] = 8'd50; tab[1] = 8'd50; tab[2] = 8'd120;
    tab[3] = 8'd50; tab[4] = 8'd50; tab[5] = 8'd50;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        wait_ms(40, c);
        if (i == 1) begin
          total++;
          if (c + 1 != 11) $display("FAIL ping_spacing got %0d expected 11", c + 1);
          else passed++;
        end
      end
      respond(tab[i]);
      if (i < 5) begin
        total++;
        if ({sound_en, state} !== {1'b0, 3'd2})
          $display("FAIL debounce_no_alarm_%0d got sound_en=%b state=%0d expected 0/2", i, sound_en, state);
        else passed++;
      end
    end
    total++;
    if ({sound_en, state} !== {1'b1, 3'd4})
      $display("FAIL debounce_alarm got sound_en=%b state=%0d expected 1/4", sound_en, state);
    else passed++;
    c = 0;
    while (sound_en === 1'b1 && c < 200) begin c++; tick(); end
    total++;
    if (c != 50) $display("FAIL alarm_hold got %0d expected 50", c);
    else passed++;
    c = 0;
    while (alarm_active === 1'b1 && c < 200) begin c++; tick(); end
    total++;
    if (c != 30 || state !== 3'd2)
      $display("FAIL cooldown got %0d cycles state=%0d expected 30 cycles state=2", c, state);
    else passed++;
  endtask

  task automatic test_boundary();
    int c;
    for (int i = 0; i < 3; i++) begin
      wait_ms(40, c);
      respond(8'd100);
    end
    total++;
    if ({sound_en, state} !== {1'b0, 3'd2})
      $display("FAIL thresh_equal got sound_en=%b state=%0d expected 0/2", sound_en, state);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      wait_ms(40, c);
      respond(8'd99);
    end
    total++;
    if ({sound_en, state} !== {1'b1, 3'd4})
      $display("FAIL thresh_below got sound_en=%b state=%0d expected 1/4", sound_en, state);
    else passed++;
    wait_state(3'd2, 200, c);
    total++;
    if (c != 80) $display("FAIL alarm_to_wait got %0d expected 80", c);
    else passed++;
  endtask

  task automatic test_timeout_fault();
    int c;
    wait_ms(40, c);
    for (int i = 0; i < 3; i++) begin
      wait_ms(60, c);
      total++;
      if (c != 30 || sensor_fault !== 1'b0)
        $display("FAIL timeout_spacing_%0d got %0d fault=%b expected 30 fault=0", i, c, sensor_fault);
      else passed++;
    end
    repeat (19) tick();
    total++;
    if ({state, sensor_fault} !== {3'd3, 1'b0})
      $display("FAIL fault_early got state=%0d fault=%b expected 3/0", state, sensor_fault);
    else passed++;
    tick();
    total++;
    if ({state, sensor_fault} !== {3'd2, 1'b1})
      $display("FAIL fault_set got state=%0d fault=%b expected 2/1", state, sensor_fault);
    else passed++;
    wait_ms(40, c);
    respond(8'd200);
    total++;
    if (sensor_fault !== 1'b1) $display("FAIL fault_sticky got %b expected 1", sensor_fault);
    else passed++;
    arm = 1'b0;
    tick();
    total++;
    if ({state, sensor_fault} !== {3'd0, 1'b0})
      $display("FAIL fault_clear got state=%0d fault=%b expected 0/0", state, sensor_fault);
    else passed++;
    arm = 1'b1;
    tick();
    codec_ready = 1'b1;
    tick();
    codec_ready = 1'b0;
  endtask

  task automatic test_races();
    int c;
    wait_ms(40, c);
    repeat (19) tick();
    respond(8'd10);
    total++;
    if ({state, sensor_fault} !== {3'd2, 1'b0})
      $display("FAIL race_timeout_cycle got state=%0d fault=%b expected 2/0", state, sensor_fault);
    else passed++;
    repeat (3) tick();
    respond(8'd10);
    total++;
    if (state !== 3'd2) $display("FAIL done_in_wait got state=%0d expected 2", state);
    else passed++;
    wait_ms(40, c);
    respond(8'd10);
    total++;
    if ({sound_en, state} !== {1'b0, 3'd2})
      $display("FAIL race_second_hit got sound_en=%b state=%0d expected 0/2", sound_en, state);
    else passed++;
    wait_ms(40, c);
    respond(8'd10);
    total++;
    if (sound_en !== 1'b1) $display("FAIL race_third_hit got sound_en=%b expected 1", sound_en);
    else passed++;
    c = 0;
    while (sound_en === 1'b1 && c < 200) begin
      meas_done = (c == 5 || c == 20);
      distance  = 8'd10;
      c++;
      tick();
    end
    meas_done = 1'b0;
    total++;
    if (c != 50) $display("FAIL done_in_alarm got %0d expected 50", c);
    else passed++;
    wait_state(3'd2, 200, c);
    total++;
    if (c != 30) $display("FAIL race_cooldown got %0d expected 30", c);
    else passed++;
  endtask

  task automatic test_disarm();
    int c;
    for (int i = 0; i < 3; i++) begin
      wait_ms(40, c);
      respond(8'd10);
    end
    repeat (24) tick();
    total++;
    if ({sound_en, state} !== {1'b1, 3'd4})
      $display("FAIL alarm_cycle25 got sound_en=%b state=%0d expected 1/4", sound_en, state);
    else passed++;
    arm = 1'b0;
    tick();
    total++;
    if ({state, sound_en, alarm_active, codec_start} !== 6'b0)
      $display("FAIL disarm_mid_alarm got %b expected 000000", {state, sound_en, alarm_active, codec_start});
    else passed++;
    arm = 1'b1;
    tick();
    total++;
    if (state !== 3'd1) $display("FAIL rearm_config got state=%0d expected 1", state);
    else passed++;
    codec_ready = 1'b1;
    tick();
    codec_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_ms(40, c);
      respond(8'd10);
    end
    total++;
    if ({sound_en, state} !== {1'b0, 3'd2})
      $display("FAIL rearm_two_hits got sound_en=%b state=%0d expected 0/2", sound_en, state);
    else passed++;
    wait_ms(40, c);
    respond(8'd10);
    total++;
    if ({sound_en, state} !== {1'b1, 3'd4})
      $display("FAIL rearm_third_hit got sound_en=%b state=%0d expected 1/4", sound_en, state);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_boundary();
    test_timeout_fault();
    test_races();
    test_disarm();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
